// File: rtl/exec_shift_seq_pkg.sv
// Shared definitions for the iterative shift/rotate engine: op encodings, per-pass
// chunk limits, sequencer states and the chunk-size helper.
package exec_shift_seq_pkg;

  typedef enum logic [2:0] {
    OP_ROL = 3'd0,
    OP_ROR = 3'd1,
    OP_RCL = 3'd2,
    OP_RCR = 3'd3,
    OP_SHL = 3'd4,
    OP_SHR = 3'd5,
    OP_SAL = 3'd6,
    OP_SAR = 3'd7
  } shift_op_t;

  localparam logic [3:0] CHUNK_BYTE = 4'd7;
  localparam logic [3:0] CHUNK_WORD = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Largest shift the single-cycle shifter may do this pass without exceeding width-1.
  function automatic logic [3:0] chunk_of(input logic bw, input logic [7:0] remaining);
    logic [3:0] lim;
    lim = bw ? CHUNK_WORD : CHUNK_BYTE;
    return (remaining < {4'd0, lim}) ? remaining[3:0] : lim;
  endfunction

endpackage

// File: rtl/exec_shift.sv
// Combinational 8086-style shifter/rotator for byte or word operands, count 1..width-1.
// CF is the last bit shifted out; OF follows the count-1 architectural definition.
module exec_shift
  import exec_shift_seq_pkg::*;
(
  input  logic [2:0]  func,
  input  logic        bw,
  input  logic [15:0] data,
  input  logic [3:0]  count,
  input  logic        var_cnt,
  input  logic        carry,
  output logic [15:0] result,
  output logic        carry_out,
  output logic        overflow
);

  logic [3:0]  amt;
  logic [7:0]  db;
  logic [16:0] wv, w_rcl, w_rcr, w_shl, w_shr, w_sar;
  logic [8:0]  bv, b_rcl, b_rcr, b_shl, b_shr, b_sar;
  logic [15:0] w_rol, w_ror, w_res;
  logic [7:0]  b_rol, b_ror, b_res;
  logic        w_cf, b_cf, msb, msb1, orig_msb;

  assign amt = var_cnt ? count : 4'd1;
  assign db  = data[7:0];
  assign wv  = {carry, data};
  assign bv  = {carry, db};

  always_comb begin
    w_rol = (data << amt) | (data >> (5'd16 - {1'b0, amt}));
    w_ror = (data >> amt) | (data << (5'd16 - {1'b0, amt}));
    w_rcl = (wv << amt) | (wv >> (5'd17 - {1'b0, amt}));
    w_rcr = (wv >> amt) | (wv << (5'd17 - {1'b0, amt}));
    w_shl = {1'b0, data} << amt;
    w_shr = {data, 1'b0} >> amt;
    w_sar = $signed({data, 1'b0}) >>> amt;
    b_rol = (db << amt) | (db >> (4'd8 - amt));
    b_ror = (db >> amt) | (db << (4'd8 - amt));
    b_rcl = (bv << amt) | (bv >> (5'd9 - {1'b0, amt}));
    b_rcr = (bv >> amt) | (bv << (5'd9 - {1'b0, amt}));
    b_shl = {1'b0, db} << amt;
    b_shr = {db, 1'b0} >> amt;
    b_sar = $signed({db, 1'b0}) >>> amt;
  end

  always_comb begin
    w_res = data;
    w_cf  = carry;
    b_res = db;
    b_cf  = carry;
    case (shift_op_t'(func))
      OP_ROL: begin w_res = w_rol; w_cf = w_rol[0];  b_res = b_rol; b_cf = b_rol[0]; end
      OP_ROR: begin w_res = w_ror; w_cf = w_ror[15]; b_res = b_ror; b_cf = b_ror[7]; end
      OP_RCL: begin w_res = w_rcl[15:0]; w_cf = w_rcl[16]; b_res = b_rcl[7:0]; b_cf = b_rcl[8]; end
      OP_RCR: begin w_res = w_rcr[15:0]; w_cf = w_rcr[16]; b_res = b_rcr[7:0]; b_cf = b_rcr[8]; end
      OP_SHL, OP_SAL: begin w_res = w_shl[15:0]; w_cf = w_shl[16]; b_res = b_shl[7:0]; b_cf = b_shl[8]; end
      OP_SHR: begin w_res = w_shr[16:1]; w_cf = w_shr[0]; b_res = b_shr[8:1]; b_cf = b_shr[0]; end
      OP_SAR: begin w_res = w_sar[16:1]; w_cf = w_sar[0]; b_res = b_sar[8:1]; b_cf = b_sar[0]; end
      default: ;
    endcase
  end

  assign result    = bw ? w_res : {8'd0, b_res};
  assign carry_out = bw ? w_cf : b_cf;
  assign msb       = bw ? w_res[15] : b_res[7];
  assign msb1      = bw ? w_res[14] : b_res[6];
  assign orig_msb  = bw ? data[15] : data[7];

  always_comb begin
    overflow = 1'b0;
    case (shift_op_t'(func))
      OP_ROL, OP_RCL, OP_SHL, OP_SAL: overflow = msb ^ carry_out;
      OP_ROR, OP_RCR:                 overflow = msb ^ msb1;
      OP_SHR:                         overflow = orig_msb;
      default:                        overflow = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_shift_seq.sv
// Iterative shift engine: long counts are split into per-cycle chunks through one shifter.
// Latency accept-to-done = passes + 1 cycles; oReady low while running, requests then ignored.
module exec_shift_seq
  import exec_shift_seq_pkg::*;
#(
  parameter int ITER_EN = 1
)
(
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iReq,
  output logic        oReady,
  input  logic [3:0]  iFunc,
  input  logic        iBW,
  input  logic [15:0] iData,
  input  logic [7:0]  iCount,
  input  logic        iMask,
  input  logic        iCarry,
  output logic        oDone,
  output logic [15:0] oResult,
  output logic        oCarry,
  output logic        oOverflow,
  output logic        oFlagsUpd
);

  state_t      state, state_nxt;
  logic [2:0]  func_q;
  logic        bw_q, carry_q, of_q, upd_q;
  logic [15:0] data_q;
  logic [7:0]  rem_q, eff_cnt;
  logic [3:0]  chunk;
  logic        mask_eff, accept;
  logic [15:0] sh_res;
  logic        sh_cf, sh_of;
  logic        unused_func_hi;

  assign unused_func_hi = iFunc[3];
  assign mask_eff = (ITER_EN != 0) ? iMask : 1'b1;
  assign eff_cnt  = mask_eff ? {3'b000, iCount[4:0]} : iCount;
  assign accept   = iReq & oReady;
  assign chunk    = chunk_of(bw_q, rem_q);

  always_ff @(posedge iClk) begin
    if (!iRst_n) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (iReq) state_nxt = (eff_cnt == 8'd0) ? ST_DONE : ST_RUN;
        else      state_nxt = ST_IDLE;
      end
      ST_RUN:  if (rem_q == {4'd0, chunk}) state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    oReady = 1'b1;
    oDone  = 1'b0;
    unique case (state)
      ST_RUN:  oReady = 1'b0;
      ST_DONE: oDone  = 1'b1;
      default: ;
    endcase
  end

  // The operand register doubles as the result register, so the final pass lands in oResult.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      func_q  <= 3'd0;
      bw_q    <= 1'b0;
      data_q  <= 16'd0;
      carry_q <= 1'b0;
      of_q    <= 1'b0;
      upd_q   <= 1'b0;
      rem_q   <= 8'd0;
    end else if (accept) begin
      func_q  <= iFunc[2:0];
      bw_q    <= iBW;
      data_q  <= iBW ? iData : {8'd0, iData[7:0]};
      carry_q <= iCarry;
      of_q    <= 1'b0;
      upd_q   <= (eff_cnt != 8'd0);
      rem_q   <= eff_cnt;
    end else if (state == ST_RUN) begin
      data_q  <= sh_res;
      carry_q <= sh_cf;
      of_q    <= sh_of;
      rem_q   <= rem_q - {4'd0, chunk};
    end
  end

  exec_shift u_shift (
    .func      (func_q),
    .bw        (bw_q),
    .data      (data_q),
    .count     (chunk),
    .var_cnt   (1'b1),
    .carry     (carry_q),
    .result    (sh_res),
    .carry_out (sh_cf),
    .overflow  (sh_of)
  );

  assign oResult   = data_q;
  assign oCarry    = carry_q;
  assign oOverflow = of_q;
  assign oFlagsUpd = upd_q;

endmodule

// File: tb/tb_exec_shift_seq.sv
// Directed bench for exec_shift_seq with hand-computed expected results and latencies.
module tb_exec_shift_seq;

  logic        iClk, iRst_n, iReq, iBW, iMask, iCarry;
  logic [3:0]  iFunc;
  logic [15:0] iData;
  logic [7:0]  iCount;
  logic        oReady, oDone, oCarry, oOverflow, oFlagsUpd;
  logic [15:0] oResult;

  int errors = 0;
  int checks = 0;

  exec_shift_seq #(.ITER_EN(1)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iReq(iReq), .oReady(oReady),
    .iFunc(iFunc), .iBW(iBW), .iData(iData), .iCount(iCount),
    .iMask(iMask), .iCarry(iCarry), .oDone(oDone), .oResult(oResult),
    .oCarry(oCarry), .oOverflow(oOverflow), .oFlagsUpd(oFlagsUpd)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Drive one request, return #1 after the edge where oDone is seen; lat counts from accept.
  task automatic run_op(input logic [3:0] f, input logic bw, input logic [15:0] d,
                        input logic [7:0] c, input logic m, input logic cy, output int lat);
    iReq = 1'b1; iFunc = f; iBW = bw; iData = d; iCount = c; iMask = m; iCarry = cy;
    @(posedge iClk); #1;
    iReq = 1'b0;
    lat = 1;
    while (!oDone && lat < 100) begin
      @(posedge iClk); #1;
      lat++;
    end
    if (!oDone) lat = -1;
  endtask

  task automatic test_reset();
    iRst_n = 1'b0; iReq = 1'b0; iFunc = 4'd0; iBW = 1'b0; iData = 16'd0;
    iCount = 8'd0; iMask = 1'b0; iCarry = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    checks++;
    if ({oReady, oDone, oResult, oCarry, oOverflow, oFlagsUpd} !== {1'b1, 1'b0, 16'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b done=%b res=%h cf=%b of=%b upd=%b, want rdy=1 done=0 res=0000 flags=0",
               oReady, oDone, oResult, oCarry, oOverflow, oFlagsUpd);
    end
    iRst_n = 1'b1;
    @(posedge iClk); #1;
  endtask

  task automatic test_shl_word();
    int lat;
    run_op(4'd4, 1'b1, 16'h8001, 8'd1, 1'b0, 1'b0, lat);
    checks++;
    if ({oResult, oCarry, oOverflow, oFlagsUpd} !== {16'h0002, 3'b111}) begin
      errors++;
      $display("FAIL shl_word: got res=%h cf=%b of=%b upd=%b, want res=0002 cf=1 of=1 upd=1",
               oResult, oCarry, oOverflow, oFlagsUpd);
    end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL shl_word_latency: got %0d want 2", lat); end
    @(posedge iClk); #1;
    checks++;
    if ({oDone, oReady, oResult, oCarry} !== {2'b01, 16'h0002, 1'b1}) begin
      errors++;
      $display("FAIL done_pulse_hold: got done=%b rdy=%b res=%h cf=%b, want done=0 rdy=1 res=0002 cf=1",
               oDone, oReady, oResult, oCarry);
    end
  endtask

  task automatic test_rol_byte_iter();
    int lat;
    run_op(4'd0, 1'b0, 16'h5581, 8'd9, 1'b0, 1'b0, lat);
    checks++;
    if ({oResult, oCarry, oOverflow, oFlagsUpd} !== {16'h0003, 3'b111}) begin
      errors++;
      $display("FAIL rol_byte_9: got res=%h cf=%b of=%b upd=%b, want res=0003 cf=1 of=1 upd=1",
               oResult, oCarry, oOverflow, oFlagsUpd);
    end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL rol_byte_9_latency: got %0d want 3", lat); end
    @(posedge iClk); #1;
  endtask

  task automatic test_shr_word_mask();
    int lat;
    run_op(4'd5, 1'b1, 16'hFFFF, 8'd20, 1'b0, 1'b1, lat);
    checks++;
    if ({oResult, oCarry, oOverflow} !== {16'h0000, 2'b00} || lat !== 3) begin
      errors++;
      $display("FAIL shr_word_20: got res=%h cf=%b of=%b lat=%0d, want res=0000 cf=0 of=0 lat=3",
               oResult, oCarry, oOverflow, lat);
    end
    @(posedge iClk); #1;
    run_op(4'd5, 1'b1, 16'hFFFF, 8'h21, 1'b1, 1'b0, lat);
    checks++;
    if ({oResult, oCarry, oOverflow, oFlagsUpd} !== {16'h7FFF, 3'b111} || lat !== 2) begin
      errors++;
      $display("FAIL shr_masked_21: got res=%h cf=%b of=%b upd=%b lat=%0d, want res=7fff cf=1 of=1 upd=1 lat=2",
               oResult, oCarry, oOverflow, oFlagsUpd, lat);
    end
    @(posedge iClk); #1;
  endtask

  task automatic test_rotates_misc();
    int lat;
    run_op(4'd3, 1'b0, 16'h0001, 8'd1, 1'b0, 1'b0, lat);
    checks++;
    if ({oResult, oCarry, oOverflow} !== {16'h0000, 2'b10} || lat !== 2) begin
      errors++;
      $display("FAIL rcr_byte: got res=%h cf=%b of=%b lat=%0d, want res=0000 cf=1 of=0 lat=2",
               oResult, oCarry, oOverflow, lat);
    end
    run_op(4'd1, 1'b1, 16'h0001, 8'd1, 1'b0, 1'b0, lat);
    checks++;
    if ({oResult, oCarry, oOverflow} !== {16'h8000, 2'b11}) begin
      errors++;
      $display("FAIL ror_word: got res=%h cf=%b of=%b, want res=8000 cf=1 of=1", oResult, oCarry, oOverflow);
    end
    run_op(4'd2, 1'b1, 16'h8000, 8'd1, 1'b0, 1'b0, lat);
    checks++;
    if ({oResult, oCarry, oOverflow} !== {16'h0000, 2'b11}) begin
      errors++;
      $display("FAIL rcl_word: got res=%h cf=%b of=%b, want res=0000 cf=1 of=1", oResult, oCarry, oOverflow);
    end
    run_op(4'd7, 1'b0, 16'h1280, 8'd7, 1'b0, 1'b1, lat);
    checks++;
    if ({oResult, oCarry, oOverflow} !== {16'h00FF, 2'b00}) begin
      errors++;
      $display("FAIL sar_byte_7: got res=%h cf=%b of=%b, want res=00ff cf=0 of=0", oResult, oCarry, oOverflow);
    end
    @(posedge iClk); #1;
  endtask

  task automatic test_count_zero();
    int lat;
    run_op(4'd1, 1'b1, 16'h1234, 8'd0, 1'b0, 1'b1, lat);
    checks++;
    if ({oResult, oCarry, oOverflow, oFlagsUpd} !== {16'h1234, 3'b100} || lat !== 1) begin
      errors++;
      $display("FAIL count0_word: got res=%h cf=%b of=%b upd=%b lat=%0d, want res=1234 cf=1 of=0 upd=0 lat=1",
               oResult, oCarry, oOverflow, oFlagsUpd, lat);
    end
    @(posedge iClk); #1;
    // Count 0x40 masked to 5 bits is 0, so this is also a no-op.
    run_op(4'd4, 1'b0, 16'hAB55, 8'h40, 1'b1, 1'b0, lat);
    checks++;
    if ({oResult, oCarry, oOverflow, oFlagsUpd} !== {16'h0055, 3'b000} || lat !== 1) begin
      errors++;
      $display("FAIL count0_byte_masked: got res=%h cf=%b of=%b upd=%b lat=%0d, want res=0055 cf=0 of=0 upd=0 lat=1",
               oResult, oCarry, oOverflow, oFlagsUpd, lat);
    end
    @(posedge iClk); #1;
  endtask

  task automatic test_busy_ignore();
    int lat;
    iReq = 1'b1; iFunc = 4'd4; iBW = 1'b1; iData = 16'h8001; iCount = 8'd16; iMask = 1'b0; iCarry = 1'b0;
    @(posedge iClk); #1;
    iFunc = 4'd1; iData = 16'hFFFF; iCount = 8'd0; iCarry = 1'b1;
    @(posedge iClk); #1;
    iReq = 1'b0;
    checks++;
    if ({oReady, oDone} !== 2'b00) begin
      errors++;
      $display("FAIL busy_state: got rdy=%b done=%b, want rdy=0 done=0", oReady, oDone);
    end
    lat = 2;
    while (!oDone && lat < 100) begin @(posedge iClk); #1; lat++; end
    checks++;
    if ({oResult, oCarry, oOverflow} !== {16'h0000, 2'b11} || lat !== 3) begin
      errors++;
      $display("FAIL busy_ignore_result: got res=%h cf=%b of=%b lat=%0d, want res=0000 cf=1 of=1 lat=3",
               oResult, oCarry, oOverflow, lat);
    end
    @(posedge iClk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(4'd4, 1'b0, 16'h0040, 8'd1, 1'b0, 1'b0, lat);
    checks++;
    if ({oResult, oCarry, oOverflow} !== {16'h0080, 2'b01}) begin
      errors++;
      $display("FAIL b2b_first: got res=%h cf=%b of=%b, want res=0080 cf=0 of=1", oResult, oCarry, oOverflow);
    end
    run_op(4'd7, 1'b1, 16'h8000, 8'd3, 1'b0, 1'b1, lat);
    checks++;
    if ({oResult, oCarry, oOverflow} !== {16'hF000, 2'b00} || lat !== 2) begin
      errors++;
      $display("FAIL b2b_second: got res=%h cf=%b of=%b lat=%0d, want res=f000 cf=0 of=0 lat=2",
               oResult, oCarry, oOverflow, lat);
    end
    @(posedge iClk); #1;
  endtask

  task automatic test_reset_midrun();
    bit seen_done;
    iReq = 1'b1; iFunc = 4'd4; iBW = 1'b1; iData = 16'h1234; iCount = 8'd200; iMask = 1'b0; iCarry = 1'b1;
    @(posedge iClk); #1;
    iReq = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    checks++;
    if (oReady !== 1'b0) begin errors++; $display("FAIL midrun_busy: got rdy=%b want 0", oReady); end
    iReq = 1'b1; iCount = 8'd0;
    @(posedge iClk); #1;
    iReq = 1'b0;
    checks++;
    if ({oReady, oDone} !== 2'b00) begin
      errors++;
      $display("FAIL midrun_req_ignored: got rdy=%b done=%b want rdy=0 done=0", oReady, oDone);
    end
    iRst_n = 1'b0;
    @(posedge iClk); #1;
    checks++;
    if ({oReady, oDone, oResult, oCarry, oOverflow, oFlagsUpd} !== {1'b1, 1'b0, 16'd0, 3'b000}) begin
      errors++;
      $display("FAIL midrun_reset: got rdy=%b done=%b res=%h cf=%b of=%b upd=%b, want rdy=1 done=0 res=0000 flags=0",
               oReady, oDone, oResult, oCarry, oOverflow, oFlagsUpd);
    end
    iRst_n = 1'b1;
    seen_done = 1'b0;
    repeat (30) begin
      @(posedge iClk); #1;
      if (oDone) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0 || oReady !== 1'b1) begin
      errors++;
      $display("FAIL midrun_abandon: got done_seen=%b rdy=%b, want done_seen=0 rdy=1", seen_done, oReady);
    end
  endtask

  initial begin
    test_reset();
    test_shl_word();
    test_rol_byte_iter();
    test_shr_word_mask();
    test_rotates_misc();
    test_count_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
